// File: rtl/conv_weight_bank.sv
// Double-buffered KxK weight store: beats stream into a shadow bank, and a commit
// copies the whole shadow bank into the active bank in one cycle.
module conv_weight_slot #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_commit,
  output logic [DATA_W-1:0] o_act
);
  logic [DATA_W-1:0] shadow;

  // wr and commit are mutually exclusive by construction (LOAD vs FULL)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow <= '0;
      o_act  <= '0;
    end else begin
      if (i_wr)     shadow <= i_d;
      if (i_commit) o_act  <= shadow;
    end
  end
endmodule

module conv_weight_bank #(
  parameter  int DATA_W = 8,
  parameter  int K      = 5,
  localparam int N      = K * K,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_w_valid,
  input  logic [DATA_W-1:0]   i_w,
  output logic                o_w_ready,
  input  logic                i_commit,
  output logic [N*DATA_W-1:0] o_w,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_full,
  output logic                o_bank_vld,
  output logic                o_swap
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state;

  logic wr_en, commit_go;

  // a restart in LOAD drops the beat offered on the same cycle
  assign wr_en     = (state == LOAD) && i_w_valid && !i_start;
  assign commit_go = (state == FULL) && i_commit;
  assign o_w_ready = (state == LOAD);
  assign o_full    = (state == FULL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_idx      <= '0;
      o_bank_vld <= 1'b0;
      o_swap     <= 1'b0;
    end else begin
      o_swap <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= LOAD;
            o_idx <= '0;
          end
        end
        LOAD: begin
          if (i_start) begin
            o_idx <= '0;
          end else if (i_w_valid) begin
            if (o_idx == IDX_W'(N - 1)) begin
              o_idx <= '0;
              state <= FULL;
            end else begin
              o_idx <= o_idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (i_commit) begin
            o_bank_vld <= 1'b1;
            o_swap     <= 1'b1;
            state      <= i_start ? LOAD : IDLE;
            o_idx      <= '0;
          end else if (i_start) begin
            state <= LOAD;
            o_idx <= '0;
          end
        end
        default: begin
          state <= IDLE;
          o_idx <= '0;
        end
      endcase
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_slot
    conv_weight_slot #(.DATA_W(DATA_W)) u_slot (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_wr     (wr_en && (o_idx == IDX_W'(j))),
      .i_d      (i_w),
      .i_commit (commit_go),
      .o_act    (o_w[j*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_conv_weight_bank.sv
// Directed bench for conv_weight_bank (K=5, 8-bit weights).
module tb_conv_weight_bank;
  localparam int DW = 8;
  localparam int N  = 25;
  localparam int IW = 5;

  logic            i_clk = 1'b0;
  logic            i_rst, i_start, i_w_valid, i_commit;
  logic [DW-1:0]   i_w;
  logic            o_w_ready, o_full, o_bank_vld, o_swap;
  logic [N*DW-1:0] o_w;
  logic [IW-1:0]   o_idx;

  int checks = 0;
  int errors = 0;

  conv_weight_bank #(.DATA_W(DW), .K(5)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_w_valid  (i_w_valid),
    .i_w        (i_w),
    .o_w_ready  (o_w_ready),
    .i_commit   (i_commit),
    .o_w        (o_w),
    .o_idx      (o_idx),
    .o_full     (o_full),
    .o_bank_vld (o_bank_vld),
    .o_swap     (o_swap)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pat(input logic [DW-1:0] base);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = base + DW'(j);
    return v;
  endfunction

  task automatic stream(input int n, input logic [DW-1:0] base);
    i_w_valid = 1'b1;
    for (int j = 0; j < n; j++) begin
      i_w = base + DW'(j);
      tick();
    end
    i_w_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pulse_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
  endtask

  initial begin
    int ready_cnt, cnt, cyc, unstable, idx_bad;
    logic [N*DW-1:0] exp_bp;

    i_rst = 1'b1; i_start = 1'b0; i_w_valid = 1'b0; i_commit = 1'b0; i_w = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_w", o_w, '0);
    chk("rst_ready", o_w_ready, 1'b0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_vld", o_bank_vld, 1'b0);
    chk("rst_swap", o_swap, 1'b0);
    chk("rst_idx", o_idx, '0);

    // 1: full load, values 1..25
    pulse_start();
    ready_cnt = 0;
    i_w_valid = 1'b1;
    for (int j = 0; j < N + 3; j++) begin
      i_w = DW'(j + 1);
      if (o_w_ready) ready_cnt++;
      tick();
    end
    i_w_valid = 1'b0;
    chk("t1_ready_cnt", ready_cnt, 25);
    chk("t1_full", o_full, 1'b1);
    chk("t1_idx", o_idx, '0);
    chk("t1_w_before", o_w, '0);
    pulse_commit();
    chk("t1_w_after", o_w, pat(8'h01));
    chk("t1_swap", o_swap, 1'b1);
    chk("t1_vld", o_bank_vld, 1'b1);
    chk("t1_full_clr", o_full, 1'b0);
    tick();
    chk("t1_swap_once", o_swap, 1'b0);

    // 3: load next kernel while the active one stays put
    pulse_start();
    unstable = 0;
    i_w_valid = 1'b1;
    for (int j = 0; j < N; j++) begin
      i_w = 8'hA0 + DW'(j);
      tick();
      if (o_w !== pat(8'h01)) unstable++;
    end
    i_w_valid = 1'b0;
    tick(); tick();
    if (o_w !== pat(8'h01)) unstable++;
    chk("t3_stable", unstable, 0);
    chk("t3_full", o_full, 1'b1);
    pulse_commit();
    chk("t3_w", o_w, pat(8'hA0));

    // 2: random backpressure, junk on non-valid cycles
    pulse_start();
    cnt = 0; idx_bad = 0; cyc = 0;
    while (cnt < N && cyc < 400) begin
      i_w_valid = 1'($urandom_range(0, 1));
      i_w = i_w_valid ? 8'h60 + DW'(cnt) : 8'hEE;
      if (i_w_valid && o_w_ready) cnt++;
      tick();
      cyc++;
      if (o_idx !== IW'(cnt == N ? 0 : cnt)) idx_bad++;
    end
    i_w_valid = 1'b0;
    chk("t2_count", cnt, N);
    chk("t2_idx_track", idx_bad, 0);
    chk("t2_full", o_full, 1'b1);
    pulse_commit();
    exp_bp = pat(8'h60);
    chk("t2_w", o_w, exp_bp);

    // 4: restart mid-load, same-cycle beat dropped, beats in FULL ignored
    pulse_start();
    stream(10, 8'hF0);
    chk("t4_idx10", o_idx, IW'(10));
    i_start = 1'b1; i_w_valid = 1'b1; i_w = 8'h77;
    tick();
    i_start = 1'b0; i_w_valid = 1'b0;
    chk("t4_restart_idx", o_idx, '0);
    chk("t4_restart_ready", o_w_ready, 1'b1);
    chk("t4_w_untouched", o_w, exp_bp);
    stream(N, 8'h40);
    stream(3, 8'h55);
    chk("t4_full_ignore_idx", o_idx, '0);
    chk("t4_full_hold", o_full, 1'b1);
    pulse_commit();
    chk("t4_w", o_w, pat(8'h40));

    // 5: commit on final beat ignored; commit+start in FULL
    pulse_start();
    stream(N - 1, 8'h10);
    i_w_valid = 1'b1; i_w = 8'h10 + DW'(N - 1); i_commit = 1'b1;
    tick();
    i_w_valid = 1'b0; i_commit = 1'b0;
    chk("t5_full", o_full, 1'b1);
    chk("t5_no_swap", o_swap, 1'b0);
    chk("t5_w_kept", o_w, pat(8'h40));
    i_commit = 1'b1; i_start = 1'b1;
    tick();
    i_commit = 1'b0; i_start = 1'b0;
    chk("t5_w", o_w, pat(8'h10));
    chk("t5_swap", o_swap, 1'b1);
    chk("t5_load", o_w_ready, 1'b1);
    chk("t5_idx", o_idx, '0);
    tick();
    chk("t5_swap_once", o_swap, 1'b0);

    // 6: reset mid-load, then reset while FULL
    stream(5, 8'h30);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6a_w", o_w, '0);
    chk("t6a_vld", o_bank_vld, 1'b0);
    chk("t6a_idx", o_idx, '0);
    chk("t6a_ready", o_w_ready, 1'b0);
    pulse_start();
    stream(N, 8'h20);
    pulse_commit();
    pulse_start();
    stream(N, 8'h80);
    chk("t6b_pre_full", o_full, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6b_w", o_w, '0);
    chk("t6b_vld", o_bank_vld, 1'b0);
    chk("t6b_full", o_full, 1'b0);
    chk("t6b_ready", o_w_ready, 1'b0);
    pulse_commit();
    chk("t6b_shadow_cleared", o_w, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
